// File: rtl/turn_sequencer_fsm.sv
// turn_sequencer_fsm: game-control FSM for a two-player 3x3 board game.
// It tracks board occupancy, accepts or rejects moves, applies the turn
// timeout policy and detects wins and draws. The 4-bit state codes are fixed
// because the external 15-second turn timer decodes them directly.
module turn_sequencer_fsm #(
  parameter int AUTO_MOVE_EN = 1,
  parameter int CELLS        = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             move_valid,
  input  logic [3:0]       move_pos,
  input  logic             finished,
  input  logic [3:0]       count,
  output logic [3:0]       current_state,
  output logic [3:0]       next_state,
  output logic [CELLS-1:0] board_p1,
  output logic [CELLS-1:0] board_p2,
  output logic             active_player,
  output logic [1:0]       winner,
  output logic [3:0]       time_left,
  output logic             move_ack,
  output logic             move_err
);

  typedef enum logic [3:0] {
    IDLE     = 4'b0000,
    P1_TURN  = 4'b0001,
    VALIDATE = 4'b0010,
    P2_TURN  = 4'b0110,
    RESULT   = 4'b0111
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CELLS-1:0] board_p1_d;
  logic [CELLS-1:0] board_p2_d;
  logic             active_player_d;
  logic [1:0]       winner_d;
  logic [3:0]       move_cnt;
  logic [3:0]       move_cnt_d;
  logic             move_ack_d;
  logic             move_err_d;

  logic [CELLS-1:0] occ;
  logic [15:0]      occ_ext;
  logic [CELLS-1:0] place_mask;
  logic [3:0]       free_idx;
  logic             mover;
  logic             legal;

  // True when any of the eight rows, columns or diagonals is fully owned.
  function automatic logic has_line(input logic [CELLS-1:0] b);
    has_line = (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  // Lowest-index empty cell; returns 15 when the board is full.
  function automatic logic [3:0] lowest_free(input logic [CELLS-1:0] o);
    lowest_free = 4'd15;
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (!o[i]) lowest_free = 4'(i);
    end
  endfunction

  assign occ           = board_p1 | board_p2;
  // Zero-extended so out-of-range positions 9..15 index a defined 0 bit.
  assign occ_ext       = {{(16 - CELLS){1'b0}}, occ};
  assign mover         = (state == P2_TURN);
  assign legal         = move_valid && (move_pos < 4'(CELLS)) && !occ_ext[move_pos];
  assign free_idx      = lowest_free(occ);
  assign current_state = state;
  assign next_state    = state_d;
  assign time_left     = ((state == P1_TURN) || (state == P2_TURN)) ? (4'd15 - count) : 4'd0;

  // Next-state, board, score and handshake decisions for the coming edge.
  always_comb begin
    state_d         = state;
    board_p1_d      = board_p1;
    board_p2_d      = board_p2;
    active_player_d = active_player;
    winner_d        = winner;
    move_cnt_d      = move_cnt;
    move_ack_d      = 1'b0;
    move_err_d      = 1'b0;
    place_mask      = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d         = P1_TURN;
          board_p1_d      = '0;
          board_p2_d      = '0;
          winner_d        = 2'b00;
          move_cnt_d      = 4'd0;
          active_player_d = 1'b0;
        end
      end
      P1_TURN, P2_TURN: begin
        if (legal) begin
          place_mask = {{(CELLS - 1){1'b0}}, 1'b1} << move_pos;
          move_cnt_d = move_cnt + 4'd1;
          move_ack_d = 1'b1;
          state_d    = VALIDATE;
        end else begin
          // An illegal move is still reported even when the timeout wins.
          move_err_d = move_valid;
          if (finished) begin
            if ((AUTO_MOVE_EN != 0) && (free_idx < 4'(CELLS))) begin
              place_mask = {{(CELLS - 1){1'b0}}, 1'b1} << free_idx;
              move_cnt_d = move_cnt + 4'd1;
              state_d    = VALIDATE;
            end else begin
              // Forfeit: hand the turn over; the code change restarts the timer.
              active_player_d = ~mover;
              state_d         = mover ? P1_TURN : P2_TURN;
            end
          end
        end
        if (mover) board_p2_d = board_p2 | place_mask;
        else       board_p1_d = board_p1 | place_mask;
      end
      VALIDATE: begin
        if (has_line(active_player ? board_p2 : board_p1)) begin
          winner_d = active_player ? 2'b10 : 2'b01;
          state_d  = RESULT;
        end else if (move_cnt == 4'(CELLS)) begin
          winner_d = 2'b11;
          state_d  = RESULT;
        end else begin
          active_player_d = ~active_player;
          state_d         = active_player ? P1_TURN : P2_TURN;
        end
      end
      RESULT: begin
        if (start) begin
          state_d         = P1_TURN;
          board_p1_d      = '0;
          board_p2_d      = '0;
          winner_d        = 2'b00;
          move_cnt_d      = 4'd0;
          active_player_d = 1'b0;
        end else if (finished) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and game registers; async reset wipes any partial game at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      board_p1      <= '0;
      board_p2      <= '0;
      active_player <= 1'b0;
      winner        <= 2'b00;
      move_cnt      <= 4'd0;
      move_ack      <= 1'b0;
      move_err      <= 1'b0;
    end else begin
      state         <= state_d;
      board_p1      <= board_p1_d;
      board_p2      <= board_p2_d;
      active_player <= active_player_d;
      winner        <= winner_d;
      move_cnt      <= move_cnt_d;
      move_ack      <= move_ack_d;
      move_err      <= move_err_d;
    end
  end

endmodule

// File: tb/tb_turn_sequencer_fsm.sv
// Bench for turn_sequencer_fsm: one instance with auto-move on timeout and
// one with forfeit, both driven by the same inputs and compared every cycle
// against a cell-array game model, plus directed game scenarios.
module tb_turn_sequencer_fsm;

  localparam int PH_IDLE = 0;
  localparam int PH_P1   = 1;
  localparam int PH_VAL  = 2;
  localparam int PH_P2   = 6;
  localparam int PH_RES  = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] move_pos = 4'd0;
  logic       finished = 1'b0;
  logic [3:0] count = 4'd0;

  logic [3:0] cs [2];
  logic [3:0] ns [2];
  logic [8:0] b1 [2];
  logic [8:0] b2 [2];
  logic       ap [2];
  logic [1:0] win [2];
  logic [3:0] tl [2];
  logic       ack [2];
  logic       err [2];

  int errors = 0;
  int checks = 0;

  // Game model: each cell holds 0 (empty), 1 (P1) or 2 (P2).
  int m_ph [2];
  int m_cell [2][9];
  int m_mover [2];
  int m_win [2];
  int m_moves [2];
  bit m_ack [2];
  bit m_err [2];
  int n_ph [2];
  int n_cell [2][9];
  int n_mover [2];
  int n_win [2];
  int n_moves [2];
  bit n_ack [2];
  bit n_err [2];
  logic [3:0] pre_ns [2];

  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  always #5 clk = ~clk;

  turn_sequencer_fsm #(.AUTO_MOVE_EN(1)) u_auto (
    .clk(clk), .rst(rst), .start(start), .move_valid(move_valid), .move_pos(move_pos),
    .finished(finished), .count(count), .current_state(cs[0]), .next_state(ns[0]),
    .board_p1(b1[0]), .board_p2(b2[0]), .active_player(ap[0]), .winner(win[0]),
    .time_left(tl[0]), .move_ack(ack[0]), .move_err(err[0]));

  turn_sequencer_fsm #(.AUTO_MOVE_EN(0)) u_forf (
    .clk(clk), .rst(rst), .start(start), .move_valid(move_valid), .move_pos(move_pos),
    .finished(finished), .count(count), .current_state(cs[1]), .next_state(ns[1]),
    .board_p1(b1[1]), .board_p2(b2[1]), .active_player(ap[1]), .winner(win[1]),
    .time_left(tl[1]), .move_ack(ack[1]), .move_err(err[1]));

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic int owned(input int k, input int who);
    int v = 0;
    for (int i = 0; i < 9; i++) if (m_cell[k][i] == who) v |= (1 << i);
    return v;
  endfunction

  function automatic bit three_in_row(input int k, input int who);
    for (int l = 0; l < 8; l++)
      if (n_cell[k][lines[l][0]] == who && n_cell[k][lines[l][1]] == who &&
          n_cell[k][lines[l][2]] == who) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset(input int k);
    m_ph[k] = PH_IDLE; m_mover[k] = 0; m_win[k] = 0; m_moves[k] = 0;
    m_ack[k] = 0; m_err[k] = 0;
    for (int i = 0; i < 9; i++) m_cell[k][i] = 0;
  endtask

  task automatic new_game(input int k);
    n_ph[k] = PH_P1; n_mover[k] = 0; n_win[k] = 0; n_moves[k] = 0;
    for (int i = 0; i < 9; i++) n_cell[k][i] = 0;
  endtask

  // Predict the game after the coming edge from the current inputs.
  task automatic model_next(input int k);
    int who;
    int p;
    bit placed;
    n_ph[k] = m_ph[k]; n_mover[k] = m_mover[k]; n_win[k] = m_win[k];
    n_moves[k] = m_moves[k]; n_ack[k] = 0; n_err[k] = 0;
    for (int i = 0; i < 9; i++) n_cell[k][i] = m_cell[k][i];
    p = int'(move_pos);
    case (m_ph[k])
      PH_IDLE: if (start) new_game(k);
      PH_P1, PH_P2: begin
        who = (m_ph[k] == PH_P2) ? 2 : 1;
        if (move_valid && p < 9 && m_cell[k][p] == 0) begin
          n_cell[k][p] = who; n_moves[k]++; n_ack[k] = 1; n_ph[k] = PH_VAL;
        end else begin
          n_err[k] = move_valid;
          if (finished) begin
            placed = 0;
            if (k == 0) begin
              for (int i = 0; i < 9; i++)
                if (!placed && m_cell[k][i] == 0) begin
                  n_cell[k][i] = who; placed = 1;
                end
            end
            if (placed) begin
              n_moves[k]++; n_ph[k] = PH_VAL;
            end else begin
              n_mover[k] = (who == 1) ? 1 : 0;
              n_ph[k] = (who == 1) ? PH_P2 : PH_P1;
            end
          end
        end
      end
      PH_VAL: begin
        if (three_in_row(k, m_mover[k] + 1)) begin
          n_win[k] = m_mover[k] + 1; n_ph[k] = PH_RES;
        end else if (m_moves[k] == 9) begin
          n_win[k] = 3; n_ph[k] = PH_RES;
        end else begin
          n_mover[k] = 1 - m_mover[k];
          n_ph[k] = (n_mover[k] == 1) ? PH_P2 : PH_P1;
        end
      end
      PH_RES: begin
        if (start) new_game(k);
        else if (finished) n_ph[k] = PH_IDLE;
      end
      default: n_ph[k] = PH_IDLE;
    endcase
  endtask

  task automatic commit(input int k);
    m_ph[k] = n_ph[k]; m_mover[k] = n_mover[k]; m_win[k] = n_win[k];
    m_moves[k] = n_moves[k]; m_ack[k] = n_ack[k]; m_err[k] = n_err[k];
    for (int i = 0; i < 9; i++) m_cell[k][i] = n_cell[k][i];
  endtask

  task automatic cmp_regs(input int k);
    chk("current_state", k, int'(cs[k]), m_ph[k]);
    chk("board_p1", k, int'(b1[k]), owned(k, 1));
    chk("board_p2", k, int'(b2[k]), owned(k, 2));
    chk("active_player", k, int'(ap[k]), m_mover[k]);
    chk("winner", k, int'(win[k]), m_win[k]);
    chk("move_ack", k, int'(ack[k]), int'(m_ack[k]));
    chk("move_err", k, int'(err[k]), int'(m_err[k]));
  endtask

  // One clock: drive at negedge, compare everything, advance past the posedge.
  task automatic cyc(input bit s, input bit mv, input int pos, input bit fin, input int c);
    @(negedge clk);
    start = s; move_valid = mv; move_pos = 4'(pos); finished = fin; count = 4'(c);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_next(k);
      cmp_regs(k);
      chk("next_state", k, int'(ns[k]), n_ph[k]);
      chk("time_left", k, int'(tl[k]),
          (m_ph[k] == PH_P1 || m_ph[k] == PH_P2) ? 15 - c : 0);
      pre_ns[k] = ns[k];
      commit(k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 3);
  endtask

  task automatic mv(input int pos);
    cyc(0, 1, pos, 0, 5);
  endtask

  // Asynchronous reset between edges, checked without any clock edge.
  task automatic async_reset();
    start = 0; move_valid = 0; finished = 0;
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      cmp_regs(k);
      chk("rst_state_lit", k, int'(cs[k]), 0);
      chk("rst_boards_lit", k, int'(b1[k] | b2[k]), 0);
      chk("rst_winner_lit", k, int'(win[k]), 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    // Reset and game start.
    async_reset();
    cyc(1, 0, 0, 0, 0);
    chk("start_state_lit", 0, int'(cs[0]), 1);
    chk("start_next_lit", 0, int'(ns[0]), 1);
    chk("start_boards_lit", 0, int'(b1[0] | b2[0]), 0);

    // P1 wins on the top row.
    mv(0); idle(); mv(3); idle(); mv(1); idle(); mv(4); idle(); mv(2);
    chk("win_validate_lit", 0, int'(cs[0]), 2);
    idle();
    chk("win_state_lit", 0, int'(cs[0]), 7);
    chk("win_p1_lit", 0, int'(b1[0]), 9'b000000111);
    chk("win_p2_lit", 0, int'(b2[0]), 9'b000011000);
    chk("win_winner_lit", 0, int'(win[0]), 1);
    cyc(0, 0, 0, 1, 15);
    chk("result_to_idle_lit", 0, int'(cs[0]), 0);

    // Illegal moves in P2_TURN.
    async_reset();
    cyc(1, 0, 0, 0, 0); mv(0); idle();
    mv(0);
    chk("occ_err_lit", 0, int'(err[0]), 1);
    chk("occ_ack_lit", 0, int'(ack[0]), 0);
    chk("occ_p2_lit", 0, int'(b2[0]), 0);
    chk("occ_state_lit", 0, int'(cs[0]), 6);
    mv(12);
    chk("range_err_lit", 0, int'(err[0]), 1);
    idle();
    chk("err_pulse_lit", 0, int'(err[0]), 0);

    // Timeouts: auto-move versus forfeit.
    async_reset();
    cyc(1, 0, 0, 0, 0); mv(0); idle(); mv(5); idle(); mv(1); idle();
    chk("to_setup_lit", 0, int'(cs[0]), 6);
    cyc(0, 0, 0, 1, 15);
    chk("auto_val_lit", 0, int'(cs[0]), 2);
    chk("auto_p2_lit", 0, int'(b2[0]), 9'b000100100);
    chk("forf_state_lit", 1, int'(cs[1]), 1);
    chk("forf_p2_lit", 1, int'(b2[1]), 9'b000100000);
    idle();
    chk("auto_back_p1_lit", 0, int'(cs[0]), 1);
    cyc(0, 0, 0, 1, 15);
    chk("forf_next_lit", 1, int'(pre_ns[1]), 6);
    chk("forf_p2turn_lit", 1, int'(cs[1]), 6);
    chk("forf_p1_keep_lit", 1, int'(b1[1]), 9'b000000011);
    chk("auto_p1_lit", 0, int'(b1[0]), 9'b000001011);

    // Draw, then asynchronous reset in RESULT.
    async_reset();
    cyc(1, 0, 0, 0, 0);
    mv(0); idle(); mv(1); idle(); mv(2); idle(); mv(4); idle(); mv(3); idle();
    mv(5); idle(); mv(7); idle(); mv(6); idle(); mv(8); idle();
    chk("draw_state_lit", 0, int'(cs[0]), 7);
    chk("draw_winner_lit", 0, int'(win[0]), 3);
    idle();
    async_reset();

    // Randomised play.
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) async_reset();
      cyc(($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 40),
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 8),
          ($urandom_range(0, 99) < 8), $urandom_range(0, 15));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/turn_sequencer_fsm.md
Name: turn_sequencer_fsm

Overview:
- Game-control FSM for the two-player 3x3 board game.
- Produces the 4-bit current_state/next_state codes that the 15-second turn timer consumes.
- Consumes the timer's finished/count outputs. Owns board occupancy, move legality, win/draw detection and the timeout policy.
- Sits between the debounced player inputs and the timer/display logic.

Parameters:
- AUTO_MOVE_EN, 1: on turn timeout, 1 = place the lowest-index free cell for the mover; 0 = forfeit the turn with no placement.
- CELLS, 9: board cell count; fixed at 9 and not overridable in practice.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a game from IDLE
- move_valid  in  1  one-cycle pulse; move_pos is valid
- move_pos  in  4  target cell 0..8, row-major
- finished  in  1  timer at 15 (level)
- count  in  4  timer seconds elapsed
- current_state  out  4  registered state code
- next_state  out  4  combinational next-state code
- board_p1  out  9  player-1 occupied cells
- board_p2  out  9  player-2 occupied cells
- active_player  out  1  0 = P1, 1 = P2
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw
- time_left  out  4  15 - count in turn states, else 0
- move_ack  out  1  one-cycle pulse; move accepted
- move_err  out  1  one-cycle pulse; move rejected

Behaviour:
- Reset values: current_state = 4'b0000; boards 0; active_player 0; winner 00; move_ack 0; move_err 0; move counter 0. next_state follows the IDLE logic.
- State codes (fixed, timer-visible):
  - IDLE 0000
  - P1_TURN 0001 (timed)
  - VALIDATE 0010 (timer cleared)
  - P2_TURN 0110 (timed)
  - RESULT 0111 (timed)
  - Unused codes recover to IDLE on the next edge.
- next_state equals the value current_state takes at the next clk edge, every cycle. The timer clears on current_state != next_state, so there must be no glitch-free-but-wrong values.
- IDLE:
  - start -> P1_TURN. Boards, move counter and winner clear on this transition; active_player = 0.
  - move_valid in IDLE is ignored, with no err.
- P1_TURN / P2_TURN, priority order:
  1. move_valid with move_pos <= 8 and cell free in (board_p1 | board_p2): set the cell in the mover's board, increment the move counter, pulse move_ack, go to VALIDATE.
  2. move_valid otherwise (pos 9..15 or occupied): pulse move_err, stay, board unchanged. If finished is also high this cycle, the timeout path is taken and move_err still pulses.
  3. finished with no legal move: if AUTO_MOVE_EN, place the lowest-index free cell for the mover, increment the counter, go to VALIDATE. Otherwise go directly to the other player's turn state with no placement. The counter is unchanged; the code change restarts the timer.
- VALIDATE (exactly 1 cycle):
  - Evaluate the 8 lines (rows 012/345/678, columns 036/147/258, diagonals 048/246) on the mover's updated board.
  - Win: winner = 01/10, go to RESULT.
  - Else, move counter == 9: winner = 11, go to RESULT.
  - Else: toggle active_player, go to P1_TURN if the new player is 0, P2_TURN if 1.
- RESULT:
  - Boards and winner are held.
  - finished -> IDLE.
  - start in RESULT -> P1_TURN with the full clear, taking priority over finished.
- time_left = 15 - count in 0001/0110, else 0. It must not underflow: count > 15 is impossible by width.
- move_ack and move_err are registered, asserted the cycle after the accepting edge, and low otherwise.
- Async rst mid-game returns all state to reset values immediately. No partial board survives.

Test Plan:
- Reset, then start -> next cycle current_state = 0001, next_state = 0001, boards 0, winner 00.
- P1 plays 0, P2 plays 3, P1 1, P2 4, P1 2 -> VALIDATE then RESULT (0111); board_p1 = 9'b000000111, board_p2 = 9'b000011000, winner = 01; finished -> IDLE.
- In P2_TURN, move_pos = 0 while cell 0 is held by P1 -> move_err one cycle, move_ack 0, board_p2 unchanged, state stays 0110. Then move_pos = 12 -> move_err again.
- AUTO_MOVE_EN = 1, P1 holds {0,1}, P2 idle in 0110 until finished -> board_p2 gains cell 2 (lowest free), 0010 for one cycle, then 0001.
- AUTO_MOVE_EN = 0, timeout in 0001 -> 0110 directly, boards unchanged, next_state = 0110 in the preceding cycle.
- Nine non-winning moves (P1: 0,2,3,7,8; P2: 1,4,5,6) -> winner = 11, state 0111. Assert rst mid-RESULT -> current_state 0000, boards 0, winner 00 without waiting for clk.
